matrix_print_formatter: RTL and testbench
=========================================

MATRIX_PRINT_FORMATTER -- requirements
Module: matrix_print_formatter

Interface
REQ-001 SHALL have parameter FIELD_WIDTH, default 8, minimum printed field width in characters (legal 1..11).
REQ-002 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-003 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  command present.
REQ-005 SHALL have port in_ready  output  1  command accepted when in_valid && in_ready.
REQ-006 SHALL have port in_kind  input  2  0 = element, 1 = end-row, 2 = end-matrix, 3 = reserved.
REQ-007 SHALL have port in_data  input  32  element value; ignored unless in_kind = 0.
REQ-008 SHALL have port out_valid  output  1  out_byte holds a valid ASCII character.
REQ-009 SHALL have port out_ready  input  1  downstream consumes a byte when out_valid && out_ready.
REQ-010 SHALL have port out_byte  output  8  ASCII character.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-012 SHALL implement states IDLE, CONVERT, EMIT_NUM, EMIT_ROW, EMIT_END.
REQ-013 SHALL drive in_ready = 1 only in IDLE; accepts at most one command per transfer.
REQ-014 On element accept, SHALL latch in_data and enter CONVERT the next cycle.
REQ-015 CONVERT SHALL run binary-to-BCD (shift/add-3) for exactly 32 cycles, producing 10 BCD digits, then enter EMIT_NUM.
REQ-016 Digit count L SHALL be the index of the most significant non-zero digit plus 1; for value 0, L = 1.
REQ-017 EMIT_NUM SHALL output max(FIELD_WIDTH-L, 0) spaces (0x20), then L digits (0x30+digit), most significant first.
REQ-018 Values wider than FIELD_WIDTH SHALL print in full with no truncation.
REQ-019 On end-row accept, SHALL enter EMIT_ROW and output the 4 bytes " ; \n" (0x20 0x3B 0x20 0x0A).
REQ-020 On end-matrix accept, SHALL enter EMIT_END and output the single byte 0x0A.
REQ-021 in_kind = 3 SHALL be accepted and discarded, producing no bytes; the FSM stays in IDLE.
REQ-022 out_valid SHALL be 1 only in EMIT_* states.
REQ-023 out_byte SHALL be held stable while out_valid && !out_ready; each byte advances only on a completed handshake.
REQ-024 out_valid SHALL not depend combinationally on out_ready.
REQ-025 After the last byte of a sequence is consumed, SHALL return to IDLE the next cycle.
REQ-026 With out_ready held 1, latency from element accept to first out_valid SHALL be 33 cycles; bytes SHALL then follow back-to-back, one per cycle.

Reset
REQ-027 When resetn = 0 at a clock edge, SHALL enter IDLE and clear the latched data, BCD register, digit counter and byte index.
REQ-028 Reset values: in_ready = 0 while resetn = 0 and 1 from the first cycle after release; out_valid = 0, out_byte = 0x00, busy = 0.
REQ-029 Reset mid-sequence SHALL abandon the sequence with no further bytes; the next command formats from scratch.

Configuration
REQ-030 With macro MATRIX_FMT_SIGNED_EN defined, SHALL treat in_data as two's complement: convert the magnitude, emit '-' (0x2D) immediately before the digits of negative values, and count the sign within FIELD_WIDTH.
REQ-031 With MATRIX_FMT_SIGNED_EN defined, 0x80000000 SHALL print as "-2147483648" (11 chars).
REQ-032 Without MATRIX_FMT_SIGNED_EN, SHALL treat in_data as unsigned and never emit '-'.
REQ-033 Sign handling SHALL add no cycles to CONVERT in either build.

Verification
REQ-034 Element 42, out_ready = 1 -> "      42" (6 spaces), first byte 33 cycles after accept, then idle.
REQ-035 Element 0, then end-row -> "       0" followed by " ; \n"; 12 bytes total.
REQ-036 Element 0xFFFFFFFF, unsigned build -> "4294967295" (10 bytes, no padding); signed build -> "      -1".
REQ-037 out_ready toggled pseudo-randomly (high 3 of 7 cycles) while printing 12345 -> byte order and values identical to the no-stall case, out_byte stable during stalls, in_ready low until the final byte.
REQ-038 resetn asserted after the 3rd byte of element 1234567 -> no further bytes; next element 7 -> "       7".
REQ-039 in_kind = 3, then end-matrix -> exactly one byte, 0x0A; in_ready high the cycle after the kind-3 accept.

Source files
------------

// File: rtl/matrix_print_formatter.sv
// matrix_print_formatter: turns a stream of matrix commands (element,
// end-row, end-matrix) into ASCII bytes. Elements are converted by a
// 32-cycle shift/add-3 pass and printed right-aligned in FIELD_WIDTH columns.
// Optional build macro MATRIX_FMT_SIGNED_EN: elements are two's complement,
// the magnitude is converted and a '-' precedes the digits of negative values.
module matrix_print_formatter #(
  parameter int unsigned FIELD_WIDTH = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_kind,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    CONVERT,
    EMIT_NUM,
    EMIT_ROW,
    EMIT_END
  } state_t;

  localparam logic [3:0] FW = 4'(FIELD_WIDTH);

  state_t      state_q;
  logic [31:0] data_q;
  logic [39:0] bcd_q;
  logic [39:0] bcd_d;
  logic [4:0]  cnt_q;
  logic [3:0]  idx_q;
  logic [3:0]  len_q;
  logic [3:0]  len_d;
  logic        neg_q;
  logic [7:0]  out_byte_q;
  logic        out_valid_q;
  logic        in_ready_q;

  // One double-dabble step: add 3 to every digit >= 5, then shift in a bit.
  function automatic logic [39:0] bcd_step(input logic [39:0] bcd, input logic b);
    logic [39:0] adj;
    logic [3:0]  dig;
    adj = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      dig = bcd[4*i +: 4];
      if (dig >= 4'd5) dig = dig + 4'd3;
      adj[4*i +: 4] = dig;
    end
    return (adj << 1) | {39'd0, b};
  endfunction

  // Number of significant decimal digits; zero still prints one digit.
  function automatic logic [3:0] digit_len(input logic [39:0] bcd);
    logic [3:0] len;
    len = 4'd1;
    for (int unsigned i = 1; i < 10; i++) begin
      if (bcd[4*i +: 4] != 4'd0) len = 4'(i + 1);
    end
    return len;
  endfunction

  // Printed width of an element: sign and digits, padded up to FIELD_WIDTH.
  function automatic logic [3:0] total_len(input logic [3:0] len, input logic neg);
    logic [3:0] body;
    body = len + {3'd0, neg};
    return (FW > body) ? FW : body;
  endfunction

  // Character at position idx of a formatted element (pad, sign, digits).
  function automatic logic [7:0] num_byte(input logic [3:0] idx, input logic [39:0] bcd,
                                          input logic [3:0] len, input logic neg);
    logic [3:0] body;
    logic [3:0] pad;
    logic [3:0] pos;
    logic [3:0] d;
    logic [3:0] dig;
    body = len + {3'd0, neg};
    pad  = (FW > body) ? (FW - body) : 4'd0;
    pos  = idx - pad - {3'd0, neg};
    d    = len - 4'd1 - pos;
    dig  = 4'd0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (d == 4'(i)) dig = bcd[4*i +: 4];
    end
    if (idx < pad) return 8'h20;
    else if (neg && (idx == pad)) return 8'h2D;
    else return {4'h3, dig};
  endfunction

  // End-of-row sequence " ; \n".
  function automatic logic [7:0] row_byte(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'h20;
      4'd1:    return 8'h3B;
      4'd2:    return 8'h20;
      default: return 8'h0A;
    endcase
  endfunction

  // Next BCD value and its length, so the first character can be registered
  // on the same edge as the final conversion step.
  always_comb begin
    bcd_d = bcd_step(bcd_q, data_q[31]);
    len_d = digit_len(bcd_d);
  end

  // Command FSM with registered handshake and byte outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      data_q      <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      len_q       <= '0;
      neg_q       <= 1'b0;
      out_byte_q  <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_ready_q && in_valid) begin
            case (in_kind)
              2'd0: begin
`ifdef MATRIX_FMT_SIGNED_EN
                data_q <= in_data[31] ? (~in_data + 32'd1) : in_data;
                neg_q  <= in_data[31];
`else
                data_q <= in_data;
                neg_q  <= 1'b0;
`endif
                bcd_q      <= '0;
                cnt_q      <= '0;
                idx_q      <= '0;
                in_ready_q <= 1'b0;
                state_q    <= CONVERT;
              end
              2'd1: begin
                idx_q       <= '0;
                out_byte_q  <= row_byte(4'd0);
                out_valid_q <= 1'b1;
                in_ready_q  <= 1'b0;
                state_q     <= EMIT_ROW;
              end
              2'd2: begin
                out_byte_q  <= 8'h0A;
                out_valid_q <= 1'b1;
                in_ready_q  <= 1'b0;
                state_q     <= EMIT_END;
              end
              default: ; // reserved kind: consumed with no output
            endcase
          end
        end
        CONVERT: begin
          bcd_q  <= bcd_d;
          data_q <= {data_q[30:0], 1'b0};
          cnt_q  <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            len_q       <= len_d;
            idx_q       <= '0;
            out_byte_q  <= num_byte(4'd0, bcd_d, len_d, neg_q);
            out_valid_q <= 1'b1;
            state_q     <= EMIT_NUM;
          end
        end
        EMIT_NUM: begin
          if (out_ready) begin
            if (idx_q == total_len(len_q, neg_q) - 4'd1) begin
              out_valid_q <= 1'b0;
              in_ready_q  <= 1'b1;
              state_q     <= IDLE;
            end else begin
              idx_q      <= idx_q + 4'd1;
              out_byte_q <= num_byte(idx_q + 4'd1, bcd_q, len_q, neg_q);
            end
          end
        end
        EMIT_ROW: begin
          if (out_ready) begin
            if (idx_q == 4'd3) begin
              out_valid_q <= 1'b0;
              in_ready_q  <= 1'b1;
              state_q     <= IDLE;
            end else begin
              idx_q      <= idx_q + 4'd1;
              out_byte_q <= row_byte(idx_q + 4'd1);
            end
          end
        end
        EMIT_END: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_byte  = out_byte_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_matrix_print_formatter.sv
// Bench for matrix_print_formatter: directed and random commands, expected
// bytes produced by a decimal-division model, random downstream stalls.
module tb_matrix_print_formatter;

  localparam int unsigned FW = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_kind = 2'd0;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_byte;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];

  matrix_print_formatter #(.FIELD_WIDTH(FW)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_kind   (in_kind),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_byte  (out_byte),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference formatting: repeated division by ten, then left padding.
  task automatic model(input logic [1:0] kind, input logic [31:0] d);
    longint unsigned mag;
    bit neg;
    logic [7:0] s[$];
    case (kind)
      2'd0: begin
        mag = longint'(d);
        neg = 1'b0;
`ifdef MATRIX_FMT_SIGNED_EN
        if (d[31]) begin
          neg = 1'b1;
          mag = 64'h1_0000_0000 - mag;
        end
`endif
        do begin
          s.push_front(8'(64'd48 + (mag % 64'd10)));
          mag = mag / 64'd10;
        end while (mag != 0);
        if (neg) s.push_front(8'h2D);
        while (s.size() < FW) s.push_front(8'h20);
        foreach (s[i]) exp_q.push_back(s[i]);
      end
      2'd1: begin
        exp_q.push_back(8'h20); exp_q.push_back(8'h3B);
        exp_q.push_back(8'h20); exp_q.push_back(8'h0A);
      end
      2'd2: exp_q.push_back(8'h0A);
      default: ;
    endcase
  endtask

  // Present one command; returns the cycle count sampled before the accept edge.
  task automatic send_cmd(input logic [1:0] kind, input logic [31:0] d, output int acc);
    int w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 100) chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_kind  = kind;
    in_data  = d;
    acc = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Consume n bytes against the scoreboard; stop early after stop_after bytes.
  task automatic collect(input int n, input int stall, input bit check_lat,
                         input int acc, input int stop_after);
    int got = 0;
    int waited = 0;
    int first = -1;
    int last = -1;
    logic prev_stall = 1'b0;
    logic [7:0] prev_byte = '0;
    while (got < n && got != stop_after && waited < 400) begin
      out_ready = (stall == 0) ? 1'b1 : ($urandom_range(0, 6) < 3);
      if (prev_stall) begin
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_hold", {24'd0, out_byte}, {24'd0, prev_byte});
      end
      chk("in_ready_low", {31'd0, in_ready}, 32'd0);
      chk("busy_high", {31'd0, busy}, 32'd1);
      if (out_valid && first < 0) begin
        first = cyc;
        if (check_lat) chk("latency", 32'(cyc - acc), 32'd33);
      end
      if (out_valid && out_ready) begin
        chk("byte", {24'd0, out_byte}, {24'd0, exp_q.pop_front()});
        got++;
        last = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_byte  = out_byte;
      @(posedge clk); #1;
      waited++;
    end
    if (got != stop_after) begin
      chk("bytes_received", 32'(got), 32'(n));
      if (stall == 0 && n > 0) chk("back_to_back", 32'(last - first), 32'(n - 1));
      chk("in_ready_after", {31'd0, in_ready}, 32'd1);
      chk("busy_after", {31'd0, busy}, 32'd0);
      chk("out_valid_after", {31'd0, out_valid}, 32'd0);
    end
    out_ready = 1'b1;
  endtask

  task automatic run(input logic [1:0] kind, input logic [31:0] d, input int stall);
    int acc;
    int n;
    model(kind, d);
    n = exp_q.size();
    send_cmd(kind, d, acc);
    collect(n, stall, kind == 2'd0, acc, -1);
  endtask

  initial begin
    int acc;
    bit seen;
    logic [1:0] k;
    logic [31:0] v;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_byte", {24'd0, out_byte}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

    run(2'd0, 32'd42, 0);
    run(2'd0, 32'd0, 0);
    run(2'd1, 32'd0, 0);
    run(2'd0, 32'hFFFF_FFFF, 0);
    run(2'd0, 32'd12345, 1);
    run(2'd0, 32'h8000_0000, 1);
    run(2'd0, 32'd99999999, 0);
    run(2'd0, 32'd123456789, 1);

    // Reset partway through an element.
    model(2'd0, 32'd1234567);
    send_cmd(2'd0, 32'd1234567, acc);
    collect(exp_q.size(), 0, 1'b1, acc, 3);
    exp_q.delete();
    out_ready = 1'b0;
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_out_byte", {24'd0, out_byte}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    resetn = 1'b1;
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("midrst_no_bytes", {31'd0, seen}, 32'd0);
    run(2'd0, 32'd7, 0);

    // Reserved kind is swallowed, then end-matrix gives a single newline.
    send_cmd(2'd3, 32'hDEAD_BEEF, acc);
    chk("k3_in_ready", {31'd0, in_ready}, 32'd1);
    chk("k3_busy", {31'd0, busy}, 32'd0);
    chk("k3_out_valid", {31'd0, out_valid}, 32'd0);
    run(2'd2, 32'd0, 0);

    for (int i = 0; i < 10; i++) begin
      k = ($urandom_range(0, 9) < 7) ? 2'd0 : 2'($urandom_range(1, 3));
      v = $urandom >> $urandom_range(0, 31);
      run(k, v, int'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
